barrier_unit: RTL and testbench

BARRIER_UNIT -- requirements
Module: barrier_unit

---
 rtl/barrier_unit.sv | 112 +++++++++++
 tb/tb_barrier_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/barrier_unit.sv
// Hardware barrier: gathers one arrival pulse from each participating core, then
// emits a one-cycle release; stuck episodes are aborted after a programmable budget.
module barrier_unit #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_W = 16,
  parameter int GEN_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] part_mask_i,
  input  logic [NUM_CORES-1:0] core_arrive_i,
  input  logic [TIMEOUT_W-1:0] timeout_limit_i,
  input  logic                 timeout_clr_i,
  output logic                 release_o,
  output logic [NUM_CORES-1:0] arrived_o,
  output logic [GEN_W-1:0]     generation_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, GATHER, RELEASE} state_t;

  state_t               state_q;
  logic [NUM_CORES-1:0] mask_q;
  logic [NUM_CORES-1:0] arrived_q;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic [GEN_W-1:0]     gen_q;
  logic                 timeout_q;
  logic                 release_q;
  logic                 busy_q;

  logic [NUM_CORES-1:0] start_hits;
  logic [NUM_CORES-1:0] gather_hits;
  logic                 complete;
  logic                 timed_out;

  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign start_hits  = core_arrive_i & part_mask_i;
  assign gather_hits = core_arrive_i & mask_q;
  assign complete    = (arrived_q == mask_q);
  // Completion is checked first in the FSM, so a coincident limit never aborts.
  assign timed_out   = (state_q == GATHER) && !complete &&
                       (timeout_limit_i != '0) && (cnt_q == timeout_limit_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      arrived_q <= '0;
      cnt_q     <= '0;
      gen_q     <= '0;
      timeout_q <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      if (timed_out) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|start_hits) begin
            mask_q    <= part_mask_i;
            arrived_q <= start_hits;
            cnt_q     <= '0;
            state_q   <= GATHER;
            busy_q    <= 1'b1;
          end
        end
        GATHER: begin
          if (complete) begin
            state_q   <= RELEASE;
            release_q <= 1'b1;
          end else if (timed_out) begin
            arrived_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
          end else begin
            arrived_q <= arrived_q | gather_hits;
            cnt_q     <= sat_inc(cnt_q);
          end
        end
        RELEASE: begin
          // Arrivals seen here are dropped; they belong to no episode.
          arrived_q <= '0;
          gen_q     <= gen_q + 1'b1;
          state_q   <= IDLE;
          release_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          arrived_q <= '0;
          state_q   <= IDLE;
          release_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign release_o    = release_q;
  assign arrived_o    = arrived_q;
  assign generation_o = gen_q;
  assign timeout_o    = timeout_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_barrier_unit.sv
// Bench for barrier_unit: directed scenarios with literal expectations, then random
// traffic checked every cycle against an episode-level reference model.
module tb_barrier_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  pm, ca;
  logic [15:0] lim;
  logic        clr;
  logic        rel;
  logic [3:0]  arr;
  logic [3:0]  gen;
  logic        to;
  logic        busy;

  logic        pm1, ca1;
  logic        rel1, arr1, to1, busy1;
  logic [3:0]  gen1;

  int tests  = 0;
  int failed = 0;

  // Reference model state: phase 0 idle, 1 gathering, 2 releasing.
  int         m_phase;
  logic [3:0] m_mask;
  logic [3:0] m_arr;
  int         m_age;
  int         m_gen;
  logic       m_to;

  always #5 clk = ~clk;

  barrier_unit #(.NUM_CORES(4), .TIMEOUT_W(16), .GEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .part_mask_i(pm), .core_arrive_i(ca),
    .timeout_limit_i(lim), .timeout_clr_i(clr), .release_o(rel),
    .arrived_o(arr), .generation_o(gen), .timeout_o(to), .busy_o(busy)
  );

  barrier_unit #(.NUM_CORES(1), .TIMEOUT_W(16), .GEN_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .part_mask_i(pm1), .core_arrive_i(ca1),
    .timeout_limit_i(16'd0), .timeout_clr_i(1'b0), .release_o(rel1),
    .arrived_o(arr1), .generation_o(gen1), .timeout_o(to1), .busy_o(busy1)
  );

  task automatic one(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rel, input logic [3:0] e_arr,
                         input logic [3:0] e_gen, input logic e_to, input logic e_busy);
    one({tag, ".release"},    {3'b0, rel},  {3'b0, e_rel});
    one({tag, ".arrived"},    arr,          e_arr);
    one({tag, ".generation"}, gen,          e_gen);
    one({tag, ".timeout"},    {3'b0, to},   {3'b0, e_to});
    one({tag, ".busy"},       {3'b0, busy}, {3'b0, e_busy});
  endtask

  // Episode rules applied to the inputs present at a rising edge.
  task automatic model_step();
    logic set_to;
    int   age_sat;
    set_to = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_mask = '0; m_arr = '0; m_age = 0; m_gen = 0; m_to = 1'b0;
    end else begin
      age_sat = (m_age > 65535) ? 65535 : m_age;
      if (m_phase == 0) begin
        if ((ca & pm) != 4'b0) begin
          m_mask = pm; m_arr = ca & pm; m_age = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (m_arr == m_mask) m_phase = 2;
        else if (lim != 16'd0 && age_sat == int'(lim)) begin
          set_to = 1'b1; m_arr = '0; m_phase = 0;
        end else begin
          m_arr = m_arr | (ca & m_mask);
          m_age = m_age + 1;
        end
      end else begin
        m_phase = 0; m_arr = '0; m_gen = (m_gen + 1) % 16;
      end
      if (set_to) m_to = 1'b1;
      else if (clr) m_to = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk_all("model", m_phase == 2, m_arr, 4'(m_gen), m_to, m_phase != 0);
  endtask

  initial begin
    rst_n = 1'b0; pm = 4'hF; ca = 4'hF; lim = 16'd0; clr = 1'b0;
    pm1 = 1'b1; ca1 = 1'b1;
    m_phase = 0; m_mask = '0; m_arr = '0; m_age = 0; m_gen = 0; m_to = 1'b0;
    tick(); tick();
    chk_all("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    one("n1.reset_busy", {3'b0, busy1}, 4'h0);
    rst_n = 1'b1; ca = 4'h0; ca1 = 1'b0; pm = 4'h0;

    // Single-core instance: arrive, one GATHER cycle, release.
    ca1 = 1'b1; tick(); ca1 = 1'b0;
    one("n1.busy", {3'b0, busy1}, 4'h1);
    one("n1.rel_early", {3'b0, rel1}, 4'h0);
    tick();
    one("n1.release", {3'b0, rel1}, 4'h1);
    tick();
    one("n1.gen", gen1, 4'h1);
    one("n1.idle", {3'b0, busy1}, 4'h0);

    // Sequential completion on all four cores.
    pm = 4'hF;
    for (int i = 0; i < 4; i++) begin
      ca = 4'(1 << i); tick();
    end
    ca = 4'h0;
    chk_all("seq.gathered", 1'b0, 4'hF, 4'h0, 1'b0, 1'b1);
    tick();
    chk_all("seq.release", 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
    tick();
    chk_all("seq.done", 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);

    // Partial mask: non-participants ignored in IDLE and GATHER.
    pm = 4'b0101; ca = 4'b1010; tick();
    chk_all("part.ignored", 1'b0, 4'h0, 4'h1, 1'b0, 1'b0);
    ca = 4'b0001; tick();
    chk_all("part.start", 1'b0, 4'b0001, 4'h1, 1'b0, 1'b1);
    ca = 4'b1110; tick(); ca = 4'h0;
    chk_all("part.gather", 1'b0, 4'b0101, 4'h1, 1'b0, 1'b1);
    tick();
    chk_all("part.release", 1'b1, 4'b0101, 4'h1, 1'b0, 1'b1);
    tick();
    chk_all("part.done", 1'b0, 4'h0, 4'h2, 1'b0, 1'b0);

    // Timeout: mask change mid-episode must not complete it.
    lim = 16'd5; pm = 4'b0011; ca = 4'b0001; tick(); ca = 4'h0; pm = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    chk_all("to.waiting", 1'b0, 4'b0001, 4'h2, 1'b0, 1'b1);
    tick();
    chk_all("to.abort", 1'b0, 4'h0, 4'h2, 1'b1, 1'b0);
    tick();
    chk_all("to.sticky", 1'b0, 4'h0, 4'h2, 1'b1, 1'b0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk_all("to.cleared", 1'b0, 4'h0, 4'h2, 1'b0, 1'b0);

    // Completion coinciding with the limit wins; arrival during release dropped.
    lim = 16'd3; pm = 4'b0011; ca = 4'b0001; tick(); ca = 4'h0;
    tick(); tick();
    ca = 4'b0010; tick(); ca = 4'h0;
    tick();
    chk_all("tie.release", 1'b1, 4'b0011, 4'h2, 1'b0, 1'b1);
    ca = 4'b0011; tick(); ca = 4'h0;
    chk_all("rel.drop", 1'b0, 4'h0, 4'h3, 1'b0, 1'b0);
    tick();
    chk_all("rel.still_idle", 1'b0, 4'h0, 4'h3, 1'b0, 1'b0);

    // Generation wrap: 13 more episodes take it from 3 back to 0.
    lim = 16'd0; pm = 4'hF;
    for (int e = 0; e < 13; e++) begin
      ca = 4'hF; tick(); ca = 4'h0; tick(); tick();
    end
    chk_all("gen.wrap", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Reset mid-GATHER abandons the episode.
    ca = 4'b0011; tick(); ca = 4'h0;
    chk_all("rst.pre", 1'b0, 4'b0011, 4'h0, 1'b0, 1'b1);
    rst_n = 1'b0; ca = 4'hF; tick();
    chk_all("rst.mid", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1; ca = 4'h0; tick();
    chk_all("rst.after", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      pm    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : pm;
      ca    = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      lim   = ($urandom_range(0, 31) == 0) ? 16'($urandom_range(0, 8)) : lim;
      clr   = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
